collision_engine: RTL and testbench
===================================

# collision_engine

Frame-synchronous collision detector for the game datapath, sitting between the object-position registers (player, player bullet, enemy bank) and the score/health logic feeding the HUD. On each frame tick it snapshots all positions, walks the enemy bank one slot per clock using bounding-box tests, and accumulates kills, score and health. It generalises single-column grid lookup to N enemies with configurable hit radius, bullet/ship hit classification and post-hit invulnerability.

## Interface
- NUM_ENEMIES, 4: enemy slots scanned per frame (1..16)
- COORD_W, 8: coordinate width (x,y)
- HIT_R, 2: box half-size; hit when |dx|<=HIT_R and |dy|<=HIT_R
- SCORE_W, 16: score register width
- HEALTH_W, 4: health register width
- HEALTH_INIT, 5: health after reset
- POINTS, 10: score added per kill
- INVULN_FRAMES, 3: frames of damage immunity after a ship hit
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle start pulse, once per frame
- user_x, user_y  in  COORD_W each  player position
- bullet_x, bullet_y  in  COORD_W each  player bullet position
- bullet_valid  in  1  bullet in flight
- enemy_x_flat, enemy_y_flat  in  NUM_ENEMIES*COORD_W each  slot i at bits [i*COORD_W +: COORD_W]
- enemy_alive  in  NUM_ENEMIES  slot occupancy
- kill_mask  out  NUM_ENEMIES  slots destroyed this frame, valid with done
- score_inc  out  1  one-cycle pulse with done if kill occurred
- health_dec  out  1  one-cycle pulse with done if damage taken
- bullet_consumed  out  1  one-cycle pulse with done if bullet hit an enemy
- score  out  SCORE_W  running score
- health  out  HEALTH_W  running health
- dead  out  1  health == 0
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle scan-complete pulse

## Operation
- States: IDLE, SCAN, DONE. Reset -> IDLE.
- IDLE: on frame_tick, register all inputs into snapshot, clear kill_mask, bullet-used and damage flags, idx=0, -> SCAN. Inputs ignored outside snapshot.
- SCAN: test slot idx each cycle; idx==NUM_ENEMIES-1 -> DONE, else idx+1.
- Per slot, only if alive: dx/dy computed as COORD_W+1-bit absolute differences, no wrap.
- Bullet hit (bullet_valid, bullet not yet used, box test): set kill_mask[idx], set bullet-used. Lowest index wins; bullet kills at most one enemy per frame.
- Ship hit (box test vs user, same slot not bullet-killed): set damage flag. Bullet priority on the same slot.
- DONE: pulse done; score_inc/bullet_consumed if bullet-used; score += POINTS saturating at all-ones. If damage flag, invuln==0, dead==0: health -= 1 (floor 0), health_dec pulse, invuln=INVULN_FRAMES. Else if invuln>0 at this frame's DONE with no applied damage, invuln -= 1. -> IDLE.
- Damage capped at 1 per frame regardless of contacting enemies.
- dead: no further damage; kills and scoring continue.
- frame_tick while busy: ignored, no queueing.
- kill_mask holds until next frame_tick.

## Timing
- Reset values: score=0, health=HEALTH_INIT, invuln=0, kill_mask=0, all pulses 0, busy=0, dead=(HEALTH_INIT==0).
- frame_tick at cycle T: busy from T+1; done, pulses, updated score/health/kill_mask visible at T+NUM_ENEMIES+1; earliest accepted next tick T+NUM_ENEMIES+2.
- All outputs registered; no combinational input-to-output path.
- resetn low mid-scan: immediate return to IDLE, reset values, no partial pulses.

## Structure
- Shared package game_pkg: COORD_W, state encoding, default HIT_R/POINTS constants.
- Sub-module box_hit (two coordinate pairs, HIT_R param, combinational hit flag); two instances (bullet, ship).

## Test plan
- Reset, N=4: score=0, health=5, kill_mask=0, busy=0; frame_tick -> done at T+5.
- Bullet (50,40) valid, enemy1 (51,41) alive: kill_mask=0010, score=10, score_inc and bullet_consumed pulse, health=5.
- Bullet (20,20) overlaps enemies 0 and 2: kill_mask=0001 only, score=10.
- User (80,100) overlaps enemies 1 and 3: health 5->4 once; same contact on next 3 frames: no decrement; 4th frame: health=3.
- Enemy slot overlapping bullet and user: kill_mask set, health unchanged; enemy with alive=0 at user position: no effect.
- Health driven to 0: dead=1, later contacts no health_dec; score saturates at 65535; frame_tick while busy ignored; resetn mid-SCAN restores reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game datapath.
//   DEF_COORD_W : default coordinate width for object positions
//   DEF_HIT_R   : default bounding-box half-size used for collisions
//   DEF_POINTS  : default score awarded per enemy kill
//   state_e     : collision engine scan states
package game_pkg;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_HIT_R   = 2;
  localparam int DEF_POINTS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/box_hit.sv
// Combinational bounding-box overlap test between two points.
//   ax, ay : first object position
//   bx, by : second object position
//   hit    : |ax-bx| <= HIT_R and |ay-by| <= HIT_R
// Differences are taken one bit wider than the coordinates so that
// positions near 0 and near full scale are never treated as adjacent.
module box_hit #(
  parameter int COORD_W = 8,
  parameter int HIT_R   = 2
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               hit
);
  localparam logic [COORD_W:0] R = (COORD_W+1)'(HIT_R);

  logic [COORD_W:0] dx, dy;

  assign dx  = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
  assign dy  = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
  assign hit = (dx <= R) && (dy <= R);
endmodule

// File: rtl/collision_engine.sv
// Frame-synchronous collision detector.
// On frame_tick the player, bullet and enemy bank are snapshotted; the
// engine then tests one enemy slot per clock and, one cycle after the last
// slot, publishes kills, score and health changes together with done.
//   clk, resetn          : clock, async active-low reset
//   frame_tick           : start pulse (ignored while busy)
//   user_x/y             : player position
//   bullet_x/y/valid     : player bullet position and in-flight flag
//   enemy_x/y_flat       : slot i at [i*COORD_W +: COORD_W]
//   enemy_alive          : slot occupancy
//   kill_mask            : slots destroyed this frame (held until next tick)
//   score_inc, health_dec, bullet_consumed, done : one-cycle pulses
//   score, health, dead  : running game state
//   busy                 : scan in progress (SCAN or DONE)
module collision_engine
  import game_pkg::*;
#(
  parameter int NUM_ENEMIES   = 4,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int HIT_R         = DEF_HIT_R,
  parameter int SCORE_W       = 16,
  parameter int HEALTH_W      = 4,
  parameter int HEALTH_INIT   = 5,
  parameter int POINTS        = DEF_POINTS,
  parameter int INVULN_FRAMES = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           frame_tick,
  input  logic [COORD_W-1:0]             user_x,
  input  logic [COORD_W-1:0]             user_y,
  input  logic [COORD_W-1:0]             bullet_x,
  input  logic [COORD_W-1:0]             bullet_y,
  input  logic                           bullet_valid,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_x_flat,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_y_flat,
  input  logic [NUM_ENEMIES-1:0]         enemy_alive,
  output logic [NUM_ENEMIES-1:0]         kill_mask,
  output logic                           score_inc,
  output logic                           health_dec,
  output logic                           bullet_consumed,
  output logic [SCORE_W-1:0]             score,
  output logic [HEALTH_W-1:0]            health,
  output logic                           dead,
  output logic                           busy,
  output logic                           done
);
  localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int INV_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e state_q, state_d;

  logic [IDX_W-1:0]                      idx_q;
  logic [NUM_ENEMIES-1:0][COORD_W-1:0]   snap_ex, snap_ey;
  logic [NUM_ENEMIES-1:0]                snap_alive, kill_acc;
  logic [COORD_W-1:0]                    snap_ux, snap_uy, snap_bx, snap_by;
  logic                                  snap_bv, bullet_used, dmg_flag;
  logic [INV_W-1:0]                      invuln_q;

  logic             bullet_box, ship_box, slot_live, bullet_hit, ship_hit;
  logic             apply_dmg;
  logic [SCORE_W:0] score_sum;

  box_hit #(.COORD_W(COORD_W), .HIT_R(HIT_R)) u_bullet_hit (
    .ax(snap_bx), .ay(snap_by), .bx(snap_ex[idx_q]), .by(snap_ey[idx_q]), .hit(bullet_box)
  );

  box_hit #(.COORD_W(COORD_W), .HIT_R(HIT_R)) u_ship_hit (
    .ax(snap_ux), .ay(snap_uy), .bx(snap_ex[idx_q]), .by(snap_ey[idx_q]), .hit(ship_box)
  );

  // Bullet is tested first so a slot it destroys cannot also hurt the ship;
  // bullet_used makes the lowest-index overlapping slot the only kill.
  assign slot_live  = (state_q == ST_SCAN) && snap_alive[idx_q];
  assign bullet_hit = slot_live && snap_bv && !bullet_used && bullet_box;
  assign ship_hit   = slot_live && ship_box && !bullet_hit;

  assign apply_dmg = dmg_flag && (invuln_q == '0) && !dead;
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(POINTS);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_tick) state_d = ST_SCAN;
      ST_SCAN: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q           <= '0;
      snap_ex         <= '0;
      snap_ey         <= '0;
      snap_alive      <= '0;
      snap_ux         <= '0;
      snap_uy         <= '0;
      snap_bx         <= '0;
      snap_by         <= '0;
      snap_bv         <= 1'b0;
      kill_acc        <= '0;
      bullet_used     <= 1'b0;
      dmg_flag        <= 1'b0;
      invuln_q        <= '0;
      kill_mask       <= '0;
      score_inc       <= 1'b0;
      health_dec      <= 1'b0;
      bullet_consumed <= 1'b0;
      done            <= 1'b0;
      score           <= '0;
      health          <= HEALTH_W'(HEALTH_INIT);
      dead            <= (HEALTH_INIT == 0);
    end else begin
      done            <= 1'b0;
      score_inc       <= 1'b0;
      health_dec      <= 1'b0;
      bullet_consumed <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            snap_ex     <= enemy_x_flat;
            snap_ey     <= enemy_y_flat;
            snap_alive  <= enemy_alive;
            snap_ux     <= user_x;
            snap_uy     <= user_y;
            snap_bx     <= bullet_x;
            snap_by     <= bullet_y;
            snap_bv     <= bullet_valid;
            kill_acc    <= '0;
            bullet_used <= 1'b0;
            dmg_flag    <= 1'b0;
            idx_q       <= '0;
            kill_mask   <= '0;
          end
        end
        ST_SCAN: begin
          if (bullet_hit) begin
            kill_acc[idx_q] <= 1'b1;
            bullet_used     <= 1'b1;
          end
          if (ship_hit) dmg_flag <= 1'b1;
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
        end
        ST_DONE: begin
          done      <= 1'b1;
          kill_mask <= kill_acc;
          if (bullet_used) begin
            score_inc       <= 1'b1;
            bullet_consumed <= 1'b1;
            score           <= score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
          end
          // One point of damage per frame at most; invulnerability only
          // counts down on frames where no damage was applied.
          if (apply_dmg) begin
            health     <= health - HEALTH_W'(1);
            dead       <= (health == HEALTH_W'(1));
            health_dec <= 1'b1;
            invuln_q   <= INV_W'(INVULN_FRAMES);
          end else if (invuln_q != '0) begin
            invuln_q <= invuln_q - INV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_engine.sv
module tb_collision_engine;
  localparam int N  = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            frame_tick = 1'b0;
  logic [CW-1:0]   user_x, user_y, bullet_x, bullet_y;
  logic            bullet_valid;
  logic [N*CW-1:0] enemy_x_flat, enemy_y_flat;
  logic [N-1:0]    enemy_alive;
  logic [N-1:0]    kill_mask;
  logic            score_inc, health_dec, bullet_consumed, dead, busy, done;
  logic [15:0]     score;
  logic [3:0]      health;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_engine #(
    .NUM_ENEMIES(N), .COORD_W(CW), .HIT_R(2), .SCORE_W(16), .HEALTH_W(4),
    .HEALTH_INIT(5), .POINTS(10), .INVULN_FRAMES(3)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .user_x(user_x), .user_y(user_y),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_valid(bullet_valid),
    .enemy_x_flat(enemy_x_flat), .enemy_y_flat(enemy_y_flat), .enemy_alive(enemy_alive),
    .kill_mask(kill_mask), .score_inc(score_inc), .health_dec(health_dec),
    .bullet_consumed(bullet_consumed), .score(score), .health(health),
    .dead(dead), .busy(busy), .done(done)
  );

  task automatic set_enemy(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input logic a);
    enemy_x_flat[i*CW +: CW] = x;
    enemy_y_flat[i*CW +: CW] = y;
    enemy_alive[i]           = a;
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    frame_tick   = 1'b0;
    user_x       = 8'd0;
    user_y       = 8'd0;
    bullet_x     = 8'd0;
    bullet_y     = 8'd0;
    bullet_valid = 1'b0;
    for (int i = 0; i < N; i++) set_enemy(i, 8'd200, 8'd200, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  // Leaves the bench at the negedge where done is high; a timeout counts as a failure.
  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got no done exp done within 20 cycles", name); end
  endtask

  task automatic run_frame(input string name);
    start_frame();
    wait_done(name);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %0d exp 0", score); end
    checks++; if (health !== 4'd5) begin errors++; $display("FAIL reset_health got %0d exp 5", health); end
    checks++; if (kill_mask !== 4'b0000) begin errors++; $display("FAIL reset_kill_mask got %b exp 0000", kill_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %b exp 0", dead); end
    checks++; if ({done, score_inc, health_dec, bullet_consumed} !== 4'b0000)
      begin errors++; $display("FAIL reset_pulses got %b exp 0000", {done, score_inc, health_dec, bullet_consumed}); end
    start_frame();  // now just after edge T
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_T1 got %b exp 1", busy); end
    repeat (4) @(negedge clk);  // after edge T+4
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_T4 got %b exp 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_T4 got %b exp 1", busy); end
    @(negedge clk);  // after edge T+5
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lat_done_T5 got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_T5 got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_T6 got %b exp 0", done); end
  endtask

  task automatic test_bullet_kill();
    do_reset();
    bullet_x = 8'd50; bullet_y = 8'd40; bullet_valid = 1'b1;
    set_enemy(0, 8'd200, 8'd200, 1'b1);
    set_enemy(1, 8'd51, 8'd41, 1'b1);
    set_enemy(2, 8'd10, 8'd200, 1'b1);
    run_frame("bullet");
    checks++; if (kill_mask !== 4'b0010) begin errors++; $display("FAIL bullet_kill_mask got %b exp 0010", kill_mask); end
    checks++; if (score !== 16'd10) begin errors++; $display("FAIL bullet_score got %0d exp 10", score); end
    checks++; if (score_inc !== 1'b1 || bullet_consumed !== 1'b1)
      begin errors++; $display("FAIL bullet_pulses got inc=%b cons=%b exp 1 1", score_inc, bullet_consumed); end
    checks++; if (health !== 4'd5 || health_dec !== 1'b0)
      begin errors++; $display("FAIL bullet_health got %0d dec=%b exp 5 0", health, health_dec); end
    @(negedge clk);
    checks++; if (score_inc !== 1'b0 || bullet_consumed !== 1'b0)
      begin errors++; $display("FAIL bullet_pulse_width got inc=%b cons=%b exp 0 0", score_inc, bullet_consumed); end
    checks++; if (kill_mask !== 4'b0010) begin errors++; $display("FAIL bullet_mask_hold got %b exp 0010", kill_mask); end
  endtask

  task automatic test_lowest_wins();
    do_reset();
    bullet_x = 8'd20; bullet_y = 8'd20; bullet_valid = 1'b1;
    set_enemy(0, 8'd21, 8'd19, 1'b1);
    set_enemy(1, 8'd100, 8'd20, 1'b1);
    set_enemy(2, 8'd20, 8'd22, 1'b1);
    set_enemy(3, 8'd23, 8'd20, 1'b1);  // dx=3, just outside the box
    run_frame("lowest");
    checks++; if (kill_mask !== 4'b0001) begin errors++; $display("FAIL lowest_kill_mask got %b exp 0001", kill_mask); end
    checks++; if (score !== 16'd10) begin errors++; $display("FAIL lowest_score got %0d exp 10", score); end
  endtask

  task automatic test_invuln();
    logic [3:0] exp_h [5] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd3};
    logic       exp_d [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    user_x = 8'd80; user_y = 8'd100;
    set_enemy(1, 8'd81, 8'd100, 1'b1);
    set_enemy(3, 8'd79, 8'd102, 1'b1);
    for (int f = 0; f < 5; f++) begin
      run_frame("invuln");
      checks++; if (health !== exp_h[f] || health_dec !== exp_d[f])
        begin errors++; $display("FAIL invuln_f%0d got health=%0d dec=%b exp %0d %b", f, health, health_dec, exp_h[f], exp_d[f]); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    bullet_x = 8'd30; bullet_y = 8'd30; bullet_valid = 1'b1;
    user_x = 8'd31; user_y = 8'd31;
    set_enemy(0, 8'd30, 8'd31, 1'b1);
    run_frame("prio");
    checks++; if (kill_mask !== 4'b0001) begin errors++; $display("FAIL prio_kill_mask got %b exp 0001", kill_mask); end
    checks++; if (health !== 4'd5 || health_dec !== 1'b0)
      begin errors++; $display("FAIL prio_health got %0d dec=%b exp 5 0", health, health_dec); end
    bullet_valid = 1'b0;
    set_enemy(0, 8'd31, 8'd31, 1'b0);
    set_enemy(2, 8'd31, 8'd31, 1'b0);
    run_frame("notalive");
    checks++; if (health !== 4'd5 || health_dec !== 1'b0 || kill_mask !== 4'b0000)
      begin errors++; $display("FAIL notalive got health=%0d dec=%b mask=%b exp 5 0 0000", health, health_dec, kill_mask); end
  endtask

  task automatic test_dead_saturate();
    int late_dec = 0;
    do_reset();
    bullet_x = 8'd10; bullet_y = 8'd10; bullet_valid = 1'b1;
    user_x = 8'd100; user_y = 8'd100;
    set_enemy(0, 8'd10, 8'd10, 1'b1);
    set_enemy(1, 8'd100, 8'd100, 1'b1);
    // Damage lands on frames 1,5,9,13,17 -> health 0 after frame 17.
    for (int k = 1; k <= 6553; k++) begin
      run_frame("dead");
      if (k > 17 && health_dec === 1'b1) late_dec++;
      if (k == 16) begin
        checks++; if (health !== 4'd1 || dead !== 1'b0)
          begin errors++; $display("FAIL dead_f16 got health=%0d dead=%b exp 1 0", health, dead); end
      end
      if (k == 17) begin
        checks++; if (health !== 4'd0 || dead !== 1'b1 || health_dec !== 1'b1)
          begin errors++; $display("FAIL dead_f17 got health=%0d dead=%b dec=%b exp 0 1 1", health, dead, health_dec); end
      end
    end
    checks++; if (late_dec != 0) begin errors++; $display("FAIL dead_no_dec got %0d decrements exp 0", late_dec); end
    checks++; if (health !== 4'd0) begin errors++; $display("FAIL dead_health_floor got %0d exp 0", health); end
    checks++; if (score !== 16'd65530) begin errors++; $display("FAIL score_6553 got %0d exp 65530", score); end
    run_frame("sat1");
    checks++; if (score !== 16'd65535) begin errors++; $display("FAIL score_sat1 got %0d exp 65535", score); end
    run_frame("sat2");
    checks++; if (score !== 16'd65535 || score_inc !== 1'b1)
      begin errors++; $display("FAIL score_sat2 got %0d inc=%b exp 65535 1", score, score_inc); end
  endtask

  task automatic test_busy_tick();
    int extra_done = 0;
    do_reset();
    bullet_x = 8'd50; bullet_y = 8'd40; bullet_valid = 1'b0;
    set_enemy(1, 8'd51, 8'd41, 1'b1);
    start_frame();
    bullet_valid = 1'b1;  // after snapshot: must not matter
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    wait_done("busytick");
    checks++; if (kill_mask !== 4'b0000 || score !== 16'd0)
      begin errors++; $display("FAIL snapshot_hold got mask=%b score=%0d exp 0000 0", kill_mask, score); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL busy_tick_queued got %0d active cycles exp 0", extra_done); end
  endtask

  task automatic test_reset_mid_scan();
    int stray = 0;
    do_reset();
    bullet_x = 8'd50; bullet_y = 8'd40; bullet_valid = 1'b1;
    user_x = 8'd51; user_y = 8'd200;
    set_enemy(1, 8'd51, 8'd41, 1'b1);
    set_enemy(2, 8'd51, 8'd201, 1'b1);
    run_frame("premid");
    checks++; if (score !== 16'd10 || health !== 4'd4)
      begin errors++; $display("FAIL premid got score=%0d health=%0d exp 10 4", score, health); end
    start_frame();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (score !== 16'd0 || health !== 4'd5 || busy !== 1'b0 || kill_mask !== 4'b0000 || done !== 1'b0)
      begin errors++; $display("FAIL midreset got score=%0d health=%0d busy=%b mask=%b done=%b exp 0 5 0 0000 0", score, health, busy, kill_mask, done); end
    @(negedge clk) resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || score_inc === 1'b1 || health_dec === 1'b1 || busy === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midreset_stray got %0d active cycles exp 0", stray); end
  endtask

  initial begin
    test_reset();
    test_bullet_kill();
    test_lowest_wins();
    test_invuln();
    test_priority();
    test_busy_tick();
    test_reset_mid_scan();
    test_dead_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
